// File: rtl/store_drain_ctrl_pkg.sv
// Shared types for the store drain path: drain FSM encoding and the store request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the request struct is carried by both the SQ head and the D-cache write port.
package store_drain_ctrl_pkg;

    // Drain FSM states.
    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_REQ  = 2'd1,
        DRAIN_WAIT = 2'd2
    } drain_state_t;

    // Plain-vector encodings of the drain states, used by the state register.
    localparam logic [1:0] ST_IDLE = DRAIN_IDLE;
    localparam logic [1:0] ST_REQ  = DRAIN_REQ;
    localparam logic [1:0] ST_WAIT = DRAIN_WAIT;

    // One store as it leaves the SQ head and enters the D-cache / uncached write port.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wstrb;
        logic        uncached;
    } store_req_t;

    localparam store_req_t STORE_REQ_ZERO = '0;

    // Builds a request record from the individual SQ head fields.
    function automatic store_req_t pack_store_req(
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [3:0]  wstrb,
        input logic        uncached
    );
        store_req_t r;
        r.addr     = addr;
        r.data     = data;
        r.wstrb    = wstrb;
        r.uncached = uncached;
        return r;
    endfunction

endpackage

// File: rtl/store_drain_ctrl_counter.sv
// Saturating count of committed stores still sitting in the SQ (up on commit, down on pop).
// Latency: count reflects inc/dec one cycle after they are sampled.
// Backpressure: none; saturates at SQ_DEPTH, overflow and underflow are flagged by assertions.
module store_commit_counter #(
    parameter int SQ_DEPTH = 8,
    parameter int CNT_W    = $clog2(SQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SQ_DEPTH);

    logic at_max;
    logic at_zero;

    assign at_max  = (cnt == CNT_MAX);
    assign at_zero = (cnt == '0);

    // Count update: simultaneous inc and dec cancel; saturate at both ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (!at_max) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (!at_zero) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Protocol checks: no commit beyond SQ capacity, no pop without a committed entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(inc && !dec && at_max))
                else $error("store_commit_counter: commit with count already at SQ_DEPTH");
            assert (!(dec && at_zero))
                else $error("store_commit_counter: pop with no committed store");
        end
    end

endmodule

// File: rtl/store_drain_ctrl.sv
// Drains committed stores from the SQ head to the D-cache / uncached bus, one write at a time.
// Latency: fire_store at t -> dc_req_valid at t+2; cached stores issue every 2 cycles with ready high.
// Backpressure: request held stable until dc_req_ready; uncached writes also wait for dc_resp_done.
// Optional perf counters (pop count, stall cycles) are built when STORE_DRAIN_PERF_EN is defined.
module store_drain_ctrl
    import store_drain_ctrl_pkg::*;
#(
    parameter int SQ_DEPTH = 8,
    parameter int CNT_W    = $clog2(SQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire_store,
    input  logic             flush,
    input  logic             sq_head_valid,
    input  logic [31:0]      sq_head_addr,
    input  logic [31:0]      sq_head_data,
    input  logic [3:0]       sq_head_wstrb,
    input  logic             sq_head_uncached,
    output logic             sq_pop,
    output logic [CNT_W-1:0] committed_cnt,
    output logic             dc_req_valid,
    output logic [31:0]      dc_req_addr,
    output logic [31:0]      dc_req_data,
    output logic [3:0]       dc_req_wstrb,
    output logic             dc_req_uncached,
    input  logic             dc_req_ready,
    input  logic             dc_resp_done,
    output logic             store_drained
`ifdef STORE_DRAIN_PERF_EN
    ,
    output logic [31:0]      perf_store_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    store_req_t       req_q;
    store_req_t       head;
    logic             pending;
    logic             launch;
    logic             unused_flush;

    // Flush never touches drain state: committed stores must always reach memory,
    // and the SQ itself trims the uncommitted tail.
    assign unused_flush = flush;

    assign head    = pack_store_req(sq_head_addr, sq_head_data, sq_head_wstrb, sq_head_uncached);
    assign pending = (committed_cnt != '0);
    assign launch  = (state_q == ST_IDLE) && pending && sq_head_valid;

    store_commit_counter #(
        .SQ_DEPTH (SQ_DEPTH),
        .CNT_W    (CNT_W)
    ) u_commit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (fire_store),
        .dec (sq_pop),
        .cnt (committed_cnt)
    );

    // Next-state logic for the one-outstanding-write drain FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dc_req_ready) begin
                    state_d = req_q.uncached ? ST_WAIT : ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dc_resp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the SQ head when a write is launched; held unchanged through REQ and WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= STORE_REQ_ZERO;
        end else if (launch) begin
            req_q <= head;
        end
    end

    // Cached stores retire on handshake; uncached ones only once the bus reports completion.
    always_comb begin
        sq_pop = 1'b0;
        case (state_q)
            ST_REQ:  sq_pop = dc_req_ready && !req_q.uncached;
            ST_WAIT: sq_pop = dc_resp_done;
            default: sq_pop = 1'b0;
        endcase
    end

    assign dc_req_valid    = (state_q == ST_REQ);
    assign dc_req_addr     = req_q.addr;
    assign dc_req_data     = req_q.data;
    assign dc_req_wstrb    = req_q.wstrb;
    assign dc_req_uncached = req_q.uncached;
    assign store_drained   = !pending && (state_q == ST_IDLE);

    // Committed entries must be visible at the SQ head whenever the drain is idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((state_q == ST_IDLE) && pending && !sq_head_valid))
                else $error("store_drain_ctrl: committed stores pending but SQ head not valid");
        end
    end

`ifdef STORE_DRAIN_PERF_EN
    // Performance counters: retired stores, and cycles lost to backpressure or uncached completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_store_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (sq_pop) begin
                perf_store_cnt <= perf_store_cnt + 32'd1;
            end
            if ((dc_req_valid && !dc_req_ready) || (state_q == ST_WAIT)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl with an SQ model and a request scoreboard.
// Latency: checks the t+2 issue timing, uncached completion wait and reset behaviour.
// Backpressure: exercises dc_req_ready low periods and dc_resp_done timing.
module tb_store_drain_ctrl;
    import store_drain_ctrl_pkg::*;

    localparam int SQ_DEPTH = 8;
    localparam int CNT_W    = $clog2(SQ_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             fire_store;
    logic             flush;
    logic             sq_head_valid;
    logic [31:0]      sq_head_addr;
    logic [31:0]      sq_head_data;
    logic [3:0]       sq_head_wstrb;
    logic             sq_head_uncached;
    logic             sq_pop;
    logic [CNT_W-1:0] committed_cnt;
    logic             dc_req_valid;
    logic [31:0]      dc_req_addr;
    logic [31:0]      dc_req_data;
    logic [3:0]       dc_req_wstrb;
    logic             dc_req_uncached;
    logic             dc_req_ready;
    logic             dc_resp_done;
    logic             store_drained;
`ifdef STORE_DRAIN_PERF_EN
    logic [31:0]      perf_store_cnt;
    logic [31:0]      perf_stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    store_req_t sq[$];
    store_req_t exp_q[$];

    always #5 clk = ~clk;

    store_drain_ctrl #(
        .SQ_DEPTH (SQ_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fire_store       (fire_store),
        .flush            (flush),
        .sq_head_valid    (sq_head_valid),
        .sq_head_addr     (sq_head_addr),
        .sq_head_data     (sq_head_data),
        .sq_head_wstrb    (sq_head_wstrb),
        .sq_head_uncached (sq_head_uncached),
        .sq_pop           (sq_pop),
        .committed_cnt    (committed_cnt),
        .dc_req_valid     (dc_req_valid),
        .dc_req_addr      (dc_req_addr),
        .dc_req_data      (dc_req_data),
        .dc_req_wstrb     (dc_req_wstrb),
        .dc_req_uncached  (dc_req_uncached),
        .dc_req_ready     (dc_req_ready),
        .dc_resp_done     (dc_resp_done),
        .store_drained    (store_drained)
`ifdef STORE_DRAIN_PERF_EN
        ,
        .perf_store_cnt   (perf_store_cnt),
        .perf_stall_cnt   (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the SQ model head on the DUT inputs.
    task automatic drive_head();
        if (sq.size() != 0) begin
            sq_head_valid    = 1'b1;
            sq_head_addr     = sq[0].addr;
            sq_head_data     = sq[0].data;
            sq_head_wstrb    = sq[0].wstrb;
            sq_head_uncached = sq[0].uncached;
        end else begin
            sq_head_valid    = 1'b0;
            sq_head_addr     = '0;
            sq_head_data     = '0;
            sq_head_wstrb    = '0;
            sq_head_uncached = 1'b0;
        end
    endtask

    // Commit one store this cycle: it is in the SQ and expected on the write port in order.
    task automatic commit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic u);
        store_req_t e;
        e.addr     = a;
        e.data     = d;
        e.wstrb    = s;
        e.uncached = u;
        sq.push_back(e);
        exp_q.push_back(e);
        fire_store = 1'b1;
        drive_head();
    endtask

    // Close the current cycle: score any handshake, advance the clock, update the SQ model,
    // drop single-cycle pulses. Returns 1ns after the rising edge.
    task automatic tick();
        logic       pop_now;
        store_req_t got;
        store_req_t want;
        pop_now = sq_pop;
        if (dc_req_valid === 1'b1 && dc_req_ready === 1'b1) begin
            got.addr     = dc_req_addr;
            got.data     = dc_req_data;
            got.wstrb    = dc_req_wstrb;
            got.uncached = dc_req_uncached;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_req", 128'(exp_q.size()), 128'd1);
            end else begin
                want = exp_q.pop_front();
                chk("sb_req", 128'(got), 128'(want));
            end
        end
        @(posedge clk);
        #1;
        if (rst === 1'b1) begin
            sq.delete();
            exp_q.delete();
        end else if (pop_now === 1'b1 && sq.size() != 0) begin
            sq.delete(0);
        end
        fire_store   = 1'b0;
        flush        = 1'b0;
        dc_resp_done = 1'b0;
        rst          = 1'b0;
        drive_head();
    endtask

    initial begin
        int pops;
        int vcyc;

        rst          = 1'b1;
        fire_store   = 1'b0;
        flush        = 1'b0;
        dc_req_ready = 1'b0;
        dc_resp_done = 1'b0;
        drive_head();

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_valid",   128'(dc_req_valid),  128'd0);
        chk("rst_pop",     128'(sq_pop),        128'd0);
        chk("rst_cnt",     128'(committed_cnt), 128'd0);
        chk("rst_drained", 128'(store_drained), 128'd1);
        chk("rst_addr",    128'(dc_req_addr),   128'd0);
        chk("rst_data",    128'(dc_req_data),   128'd0);
`ifdef STORE_DRAIN_PERF_EN
        chk("rst_perf_store", 128'(perf_store_cnt), 128'd0);
        chk("rst_perf_stall", 128'(perf_stall_cnt), 128'd0);
`endif

        // Single cached store with ready high
        tick();
        dc_req_ready = 1'b1;
        commit(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        @(negedge clk);
        chk("c1_t0_cnt", 128'(committed_cnt), 128'd0);
        tick();
        @(negedge clk);
        chk("c1_t1_cnt",     128'(committed_cnt), 128'd1);
        chk("c1_t1_valid",   128'(dc_req_valid),  128'd0);
        chk("c1_t1_drained", 128'(store_drained), 128'd0);
        tick();
        @(negedge clk);
        chk("c1_t2_valid", 128'(dc_req_valid), 128'd1);
        chk("c1_t2_addr",  128'(dc_req_addr),  128'h8000_0010);
        chk("c1_t2_data",  128'(dc_req_data),  128'hDEAD_BEEF);
        chk("c1_t2_wstrb", 128'(dc_req_wstrb), 128'hF);
        chk("c1_t2_pop",   128'(sq_pop),       128'd1);
        tick();
        @(negedge clk);
        chk("c1_t3_cnt",     128'(committed_cnt), 128'd0);
        chk("c1_t3_drained", 128'(store_drained), 128'd1);
        chk("c1_t3_pop",     128'(sq_pop),        128'd0);

        // Back-pressure: three commits, ready low for five cycles
        tick();
        dc_req_ready = 1'b0;
        commit(32'h1000_0000, 32'h1111_1111, 4'hF, 1'b0);
        @(negedge clk);
        tick();
        commit(32'h1000_0004, 32'h2222_2222, 4'h3, 1'b0);
        @(negedge clk);
        tick();
        commit(32'h1000_0008, 32'h3333_3333, 4'hC, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("bp_hold_valid", 128'(dc_req_valid),  128'd1);
            chk("bp_hold_addr",  128'(dc_req_addr),   128'h1000_0000);
            chk("bp_hold_data",  128'(dc_req_data),   128'h1111_1111);
            chk("bp_hold_cnt",   128'(committed_cnt), 128'd3);
            chk("bp_hold_pop",   128'(sq_pop),        128'd0);
        end
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dc_req_ready = 1'b1;
            @(negedge clk);
            chk("bp_drain_pop", 128'(sq_pop),        128'((i % 2) == 0));
            chk("bp_drain_cnt", 128'(committed_cnt), 128'(3 - ((i + 1) / 2)));
            if (sq_pop === 1'b1) pops++;
        end
        chk("bp_pop_total", 128'(pops),          128'd3);
        chk("bp_drained",   128'(store_drained), 128'd1);

        // dc_resp_done outside WAIT is ignored
        tick();
        dc_resp_done = 1'b1;
        @(negedge clk);
        chk("stray_done_pop", 128'(sq_pop),        128'd0);
        chk("stray_done_cnt", 128'(committed_cnt), 128'd0);

        // Uncached store: completion at t+6
        tick();
        commit(32'hBFAF_F000, 32'h1234_5678, 4'h3, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("uc_t1_cnt", 128'(committed_cnt), 128'd1);
        tick();
        @(negedge clk);
        chk("uc_t2_valid", 128'(dc_req_valid),    128'd1);
        chk("uc_t2_uc",    128'(dc_req_uncached), 128'd1);
        chk("uc_t2_addr",  128'(dc_req_addr),     128'hBFAF_F000);
        chk("uc_t2_pop",   128'(sq_pop),          128'd0);
        for (int k = 3; k <= 5; k++) begin
            tick();
            @(negedge clk);
            chk("uc_wait_valid", 128'(dc_req_valid),  128'd0);
            chk("uc_wait_pop",   128'(sq_pop),        128'd0);
            chk("uc_wait_cnt",   128'(committed_cnt), 128'd1);
        end
        tick();
        dc_resp_done = 1'b1;
        @(negedge clk);
        chk("uc_t6_pop",   128'(sq_pop),       128'd1);
        chk("uc_t6_valid", 128'(dc_req_valid), 128'd0);
        tick();
        @(negedge clk);
        chk("uc_t7_cnt",     128'(committed_cnt), 128'd0);
        chk("uc_t7_drained", 128'(store_drained), 128'd1);

        // Flush during REQ with two committed stores
        tick();
        dc_req_ready = 1'b0;
        commit(32'h2000_0000, 32'hAAAA_0001, 4'hF, 1'b0);
        @(negedge clk);
        tick();
        commit(32'h2000_0010, 32'hAAAA_0002, 4'h1, 1'b0);
        @(negedge clk);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_req_valid", 128'(dc_req_valid),  128'd1);
        chk("fl_req_cnt",   128'(committed_cnt), 128'd2);
        tick();
        dc_req_ready = 1'b1;
        @(negedge clk);
        chk("fl_after_cnt",   128'(committed_cnt), 128'd2);
        chk("fl_after_valid", 128'(dc_req_valid),  128'd1);
        chk("fl_after_addr",  128'(dc_req_addr),   128'h2000_0000);
        chk("fl_after_pop",   128'(sq_pop),        128'd1);
        pops = 0;
        vcyc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            if (sq_pop === 1'b1) pops++;
            if (dc_req_valid === 1'b1) vcyc++;
        end
        chk("fl_pops",    128'(pops),          128'd1);
        chk("fl_reqs",    128'(vcyc),          128'd1);
        chk("fl_cnt_end", 128'(committed_cnt), 128'd0);

        // Simultaneous commit and pop at cnt=1
        tick();
        commit(32'h3000_0000, 32'hBBBB_0001, 4'hF, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        commit(32'h3000_0040, 32'hBBBB_0002, 4'h6, 1'b0);
        @(negedge clk);
        chk("sim_pop",     128'(sq_pop),        128'd1);
        chk("sim_cnt_now", 128'(committed_cnt), 128'd1);
        tick();
        @(negedge clk);
        chk("sim_cnt_next", 128'(committed_cnt), 128'd1);
        chk("sim_idle",     128'(dc_req_valid),  128'd0);
        tick();
        @(negedge clk);
        chk("sim_req_valid", 128'(dc_req_valid), 128'd1);
        chk("sim_req_addr",  128'(dc_req_addr),  128'h3000_0040);
        chk("sim_req_wstrb", 128'(dc_req_wstrb), 128'h6);
        tick();
        @(negedge clk);
        chk("sim_cnt_end", 128'(committed_cnt), 128'd0);

        // Reset while waiting for an uncached completion
        tick();
        commit(32'hBFAF_F100, 32'hCCCC_0001, 4'hF, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rw_wait_valid",   128'(dc_req_valid),  128'd0);
        chk("rw_wait_cnt",     128'(committed_cnt), 128'd1);
        chk("rw_wait_drained", 128'(store_drained), 128'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rw_valid",   128'(dc_req_valid),  128'd0);
        chk("rw_pop",     128'(sq_pop),        128'd0);
        chk("rw_cnt",     128'(committed_cnt), 128'd0);
        chk("rw_drained", 128'(store_drained), 128'd1);
        chk("rw_addr",    128'(dc_req_addr),   128'd0);
`ifdef STORE_DRAIN_PERF_EN
        chk("rw_perf_store", 128'(perf_store_cnt), 128'd0);
        chk("rw_perf_stall", 128'(perf_stall_cnt), 128'd0);
`endif

        chk("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
